// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encodings,
// the syscall word that can stop fetch, and the default reset address.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] SYSCALL_WORD     = 32'h0000_000C;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset, then redirect load, then sequential +4 increment.
// Loaded addresses are word aligned by clearing bits [1:0].
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] load_aligned;

    assign load_aligned = load_pc & ALIGN_MASK;

    // Modular add: the top word wraps back to address 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else if (load) begin
            pc <= load_aligned;
        end else if (inc) begin
            pc <= pc + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller with a single registered output slot.
// Define FETCH_CTRL_HALT_EN to stop fetching after a syscall is captured.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [ADDR_W-1:0] imem_data,
    output logic [ADDR_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              take_redirect;
    logic              capture;
    logic              is_syscall;

    assign slot_free     = !instr_valid || instr_ready;
    assign take_redirect = redirect && (state != HALT);
    assign capture       = (state == FETCH) && !redirect && slot_free;
    assign imem_addr     = {2'b00, pc[ADDR_W-1:2]};

`ifdef FETCH_CTRL_HALT_EN
    assign is_syscall = (imem_data == ADDR_W'(SYSCALL_WORD));
`else
    assign is_syscall = 1'b0;
`endif

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock   (clock),
        .reset   (reset),
        .load    (take_redirect),
        .load_pc (redirect_pc),
        .inc     (capture),
        .pc      (pc)
    );

    // Redirect flushes the slot; a coincident handshake has already consumed it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= FETCH;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                    end else if (slot_free) begin
                        instr       <= imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        if (is_syscall) state <= HALT;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                HALT: begin
                    // Syscall stays visible until decode takes it; nothing after.
                    if (instr_ready) instr_valid <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_CTRL_HALT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            halted <= 1'b0;
        end else if (capture && is_syscall) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Fetch controller bench: directed scenarios plus random handshake/redirect
// traffic scored against a transaction-level model of the accepted stream.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC    = 32'h0000_0000;
    localparam logic [31:0] SYSCALL_W = 32'h0000_000C;
`ifdef FETCH_CTRL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    logic [31:0] rom [32];
    int          checks = 0;
    int          errors = 0;
    bit          started = 1'b0;

    always #5 clock = ~clock;

    assign imem_data = rom[imem_addr[4:0]];

    fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == SYSCALL_W) w = 32'hDEAD_BEEF;
        return w;
    endfunction

    // Model: the ordered stream of byte PCs decode should accept. Each accept
    // pops the head and queues pc+4; an honoured redirect (applied after any
    // coincident accept) replaces the stream with the aligned target.
    logic [31:0] exp_q [$];
    bit          m_halt = 1'b0;
    bit          prev_hold = 1'b0;
    bit          prev_flush = 1'b0;
    logic [31:0] prev_instr;
    logic [31:0] prev_ipc;

    always @(negedge clock) begin
        logic [31:0] e;
        bit          halting;
        halting = HALT_EN && (m_halt || (instr_valid === 1'b1 && instr == SYSCALL_W));
        if (started) begin
            chk("halted", {31'b0, halted}, {31'b0, halting});
            if (prev_hold) begin
                chk("hold_valid", {31'b0, instr_valid}, 32'd1);
                chk("hold_instr", instr, prev_instr);
                chk("hold_pc", instr_pc, prev_ipc);
            end
            if (prev_flush) chk("flush_valid", {31'b0, instr_valid}, 32'd0);
        end
        prev_hold  = reset && instr_valid && !instr_ready && !(redirect && !halting);
        prev_flush = reset && redirect && !halting;
        prev_instr = instr;
        prev_ipc   = instr_pc;
        if (!reset) begin
            exp_q.delete();
            exp_q.push_back(RST_PC & ~32'd3);
            m_halt = 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_accept: got instr_pc %h, expected no accept", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", instr_pc, e);
                    chk("sb_instr", instr, rom[e[6:2]]);
                    if (HALT_EN && instr == SYSCALL_W) m_halt = 1'b1;
                    else exp_q.push_back(e + 32'd4);
                end
            end
            if (redirect && !halting) begin
                exp_q.delete();
                exp_q.push_back({redirect_pc[31:2], 2'b00});
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = rand_word();
        reset = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset held two cycles
        next_cycle();
        started = 1'b1;
        next_cycle();
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);

        // Streaming with ready held high: one instruction per cycle
        reset = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            chk("str_ipc", instr_pc, 32'(4 * i));
            chk("str_instr", instr, rom[i]);
            chk("str_valid", {31'b0, instr_valid}, 32'd1);
            chk("str_addr", imem_addr, 32'(i + 1));
        end

        // Backpressure at instr_pc=8
        redirect = 1'b1; redirect_pc = 32'd8; instr_ready = 1'b0;
        next_cycle();
        chk("bp_flush", {31'b0, instr_valid}, 32'd0);
        redirect = 1'b0;
        next_cycle();
        chk("bp_cap", instr_pc, 32'd8);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("bp_ipc", instr_pc, 32'd8);
            chk("bp_instr", instr, rom[2]);
            chk("bp_addr", imem_addr, 32'd3);
        end
        instr_ready = 1'b1;
        next_cycle();
        chk("bp_rel_valid", {31'b0, instr_valid}, 32'd0);
        next_cycle();
        chk("bp_next_ipc", instr_pc, 32'd12);
        chk("bp_next_valid", {31'b0, instr_valid}, 32'd1);

        // Redirect to an unaligned target
        redirect = 1'b1; redirect_pc = 32'h0000_0042;
        next_cycle();
        chk("rd_valid", {31'b0, instr_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'd16);
        redirect = 1'b0;
        next_cycle();
        chk("rd_ipc", instr_pc, 32'h40);
        chk("rd_instr", instr, rom[16]);

        // Syscall at ROM[3]
        rom[3] = SYSCALL_W;
        redirect = 1'b1; redirect_pc = 32'd0;
        next_cycle();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) next_cycle();
        chk("sys_ipc", instr_pc, 32'd12);
        chk("sys_instr", instr, SYSCALL_W);
        chk("sys_valid", {31'b0, instr_valid}, 32'd1);
        next_cycle();
`ifdef FETCH_CTRL_HALT_EN
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_valid", {31'b0, instr_valid}, 32'd0);
        chk("halt_addr", imem_addr, 32'd4);
        redirect = 1'b1; redirect_pc = 32'h80;
        next_cycle();
        next_cycle();
        chk("halt_rd_addr", imem_addr, 32'd4);
        chk("halt_rd_valid", {31'b0, instr_valid}, 32'd0);
        redirect = 1'b0;
`else
        chk("nohalt_ipc", instr_pc, 32'd16);
        chk("nohalt_valid", {31'b0, instr_valid}, 32'd1);
        chk("nohalt_flag", {31'b0, halted}, 32'd0);
`endif
        rom[3] = rand_word();

        // Reset mid-operation during HOLD with redirect asserted
        reset = 1'b0; instr_ready = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        next_cycle();
        chk("mid_rst_addr", imem_addr, RST_PC >> 2);
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_halted", {31'b0, halted}, 32'd0);
        reset = 1'b1; redirect = 1'b0; instr_ready = 1'b1;

        // Random handshake, redirect and occasional reset traffic
        for (int i = 0; i < 2000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom;
            reset       = ($urandom_range(0, 199) != 0);
            next_cycle();
        end
        reset = 1'b1; redirect = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC at reset.
REQ-002 SHALL have parameter ADDR_W, default 32, width of PC, imem_addr and instruction data.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port imem_addr  output  ADDR_W  word index to instruction ROM, combinational, = {2'b00, pc[ADDR_W-1:2]}.
REQ-006 SHALL have port imem_data  input  ADDR_W  asynchronous ROM read data for imem_addr.
REQ-007 SHALL have port instr  output  ADDR_W  registered instruction to decode.
REQ-008 SHALL have port instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-009 SHALL have port instr_ready  input  1  decode accepts instr this cycle.
REQ-010 SHALL have port instr_pc  output  ADDR_W  byte PC of instr.
REQ-011 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-012 SHALL have port redirect_pc  input  ADDR_W  target byte address.
REQ-013 SHALL have port halted  output  1  controller in HALT state.

Function
REQ-014 SHALL implement FSM states FETCH, HOLD, HALT; state encodings from shared package.
REQ-015 SHALL treat output slot as free when instr_valid==0 or instr_ready==1.
REQ-016 SHALL, in FETCH with slot free and no redirect: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4; fetch latency one cycle.
REQ-017 SHALL, in FETCH with slot not free, go to HOLD; pc, instr, instr_pc stable.
REQ-018 SHALL, in HOLD, return to FETCH on the cycle instr_ready==1; instr_valid<=0 that cycle, no capture.
REQ-019 SHALL give redirect priority over capture and handshake in FETCH/HOLD: pc<={redirect_pc[ADDR_W-1:2],2'b00}, instr_valid<=0, state<=FETCH.
REQ-020 SHALL keep instr_valid's prior transfer complete if instr_ready and redirect coincide (instruction counted consumed, then flushed).
REQ-021 SHALL wrap pc from 32'hFFFF_FFFC to 0 by modular add; ROM index wrap at 32 words is the ROM's concern.
REQ-022 SHALL ignore imem_data outside a capture cycle.
REQ-023 SHALL drive halted=1 only in HALT; HALT exits only through reset.

Reset
REQ-024 SHALL, when reset==0 at a rising edge, set pc=RESET_PC with bits [1:0] forced 0, state=FETCH, instr=0, instr_pc=0, instr_valid=0, halted=0.
REQ-025 SHALL give reset priority over redirect, handshake and halt, mid-operation included.

Configuration
REQ-026 SHALL support macro FETCH_CTRL_HALT_EN.
REQ-027 SHALL, with FETCH_CTRL_HALT_EN defined, enter HALT when a captured instruction equals 32'h0000_000C (syscall); instr stays valid until consumed, then no further fetches, pc frozen, redirect ignored.
REQ-028 SHALL, without FETCH_CTRL_HALT_EN, fetch syscall like any instruction, never enter HALT, tie halted to 0.

Structure
REQ-029 SHALL take FSM state encodings, SYSCALL_WORD constant and default RESET_PC from shared package mips_pkg.
REQ-030 SHALL place PC register plus redirect/increment mux in sub-module fetch_pc_reg; i_mem is instantiated outside fetch_ctrl.

Verification
REQ-031 SHALL cover reset: reset=0 two cycles, RESET_PC=0 -> pc=0, imem_addr=0, instr_valid=0; first cycle after release instr=ROM[0], instr_pc=0.
REQ-032 SHALL cover streaming: instr_ready=1 held, 5 cycles -> instr_pc 0,4,8,12,16, imem_addr 0..5, valid every cycle.
REQ-033 SHALL cover backpressure: instr_ready=0 three cycles at instr_pc=8 -> instr, instr_pc stable, pc=12; ready=1 -> next capture instr_pc=12.
REQ-034 SHALL cover redirect: redirect=1, redirect_pc=32'h0000_0042 -> next cycle instr_valid=0, pc=32'h40, imem_addr=16; following cycle instr_pc=32'h40.
REQ-035 SHALL cover halt (macro on): ROM[3]=32'h0000_000C -> instr_pc=12 valid, after consume halted=1, pc frozen, redirect ignored; macro off -> fetch continues at 16.
REQ-036 SHALL cover reset mid-operation: reset=0 with redirect=1 during HOLD -> pc=RESET_PC, instr_valid=0, halted=0.
